// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the count sequence checker.
// Holds the checker state encoding and the per-sample error-event encoding.
package count_chk_pkg;

   localparam int DEF_CNT_W     = 3;
   localparam int DEF_MAX_COUNT = 3;

   typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

   typedef enum logic [1:0] {EV_NONE, EV_OVF, EV_STEP} err_ev_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear together with an increment leaves the count at one.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= W'(inc);
      else if (inc && count != '1)
         count <= count + W'(1);
   end

endmodule

// File: rtl/count_sequence_checker.sv
// Receive-side monitor for a bounded 0..MAX_COUNT up-counter stream.
// Tracks the next expected value and records overflow / illegal-step events.
module count_sequence_checker
   import count_chk_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int MAX_COUNT = DEF_MAX_COUNT,
   parameter int ERRCNT_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CNT_W-1:0]    cnt_in,
   input  logic                cnt_valid,
   input  logic                clear_err,
   output logic [CNT_W-1:0]    expected,
   output logic                done,
   output logic                holding,
   output logic                err_overflow,
   output logic                err_step,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);

   state_t  state;
   err_ev_t ev;

   // Overflow outranks the step check so at most one event is counted per sample.
   always_comb begin
      ev = EV_NONE;
      if (cnt_valid) begin
         if (cnt_in > MAX_V)
            ev = EV_OVF;
         else begin
            case (state)
               TRACK: if (cnt_in != expected && cnt_in != expected - CNT_W'(1)) ev = EV_STEP;
               DONE:  if (cnt_in != MAX_V && cnt_in != '0) ev = EV_STEP;
               default: ev = EV_NONE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         expected     <= '0;
         done         <= 1'b0;
         holding      <= 1'b0;
         err_overflow <= 1'b0;
         err_step     <= 1'b0;
      end else begin
         done         <= 1'b0;
         err_overflow <= (err_overflow & ~clear_err) | (ev == EV_OVF);
         err_step     <= (err_step & ~clear_err) | (ev == EV_STEP);
         if (ev != EV_NONE) begin
            state    <= IDLE;
            expected <= '0;
            holding  <= 1'b0;
         end else if (cnt_valid) begin
            case (state)
               IDLE: if (cnt_in == '0) begin
                  state    <= TRACK;
                  expected <= CNT_W'(1);
               end
               TRACK: if (cnt_in == expected) begin
                  if (cnt_in == MAX_V) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     holding  <= 1'b1;
                     expected <= MAX_V;
                  end else
                     expected <= expected + CNT_W'(1);
               end
               DONE: if (cnt_in == '0) begin
                  state    <= TRACK;
                  holding  <= 1'b0;
                  expected <= CNT_W'(1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   sat_counter #(.W(ERRCNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ev != EV_NONE),
      .clear (clear_err),
      .count (err_count)
   );

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed + randomized bench for count_sequence_checker against a
// "last accepted value" reference model.
module tb_count_sequence_checker;

   localparam int CNT_W    = 3;
   localparam int MAXC     = 3;
   localparam int ERRCNT_W = 8;
   localparam int SAT      = (1 << ERRCNT_W) - 1;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [CNT_W-1:0]    cnt_in = '0;
   logic                cnt_valid = 1'b0;
   logic                clear_err = 1'b0;
   logic [CNT_W-1:0]    expected;
   logic                done;
   logic                holding;
   logic                err_overflow;
   logic                err_step;
   logic [ERRCNT_W-1:0] err_count;

   int checks = 0;
   int errors = 0;

   // model: synchronised flag plus last accepted value
   bit m_sync, m_done, m_ovf, m_step;
   int m_last, m_cnt;

   count_sequence_checker #(.CNT_W(CNT_W), .MAX_COUNT(MAXC), .ERRCNT_W(ERRCNT_W)) dut (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
      .clear_err(clear_err), .expected(expected), .done(done), .holding(holding),
      .err_overflow(err_overflow), .err_step(err_step), .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic int m_expected();
      if (!m_sync) return 0;
      return (m_last == MAXC) ? MAXC : m_last + 1;
   endfunction

   task automatic model_reset();
      m_sync = 0; m_last = 0; m_done = 0; m_ovf = 0; m_step = 0; m_cnt = 0;
   endtask

   task automatic model_update(input bit v, input int val, input bit clr);
      bit ovf_ev, step_ev;
      ovf_ev = 0; step_ev = 0; m_done = 0;
      if (clr) begin m_ovf = 0; m_step = 0; m_cnt = 0; end
      if (v) begin
         if (val > MAXC) begin ovf_ev = 1; m_sync = 0; end
         else if (!m_sync) begin
            if (val == 0) begin m_sync = 1; m_last = 0; end
         end
         else if (val == m_last) begin end
         else if (val == m_last + 1) begin m_last = val; m_done = (val == MAXC); end
         else if (m_last == MAXC && val == 0) m_last = 0;
         else begin step_ev = 1; m_sync = 0; end
      end
      if (ovf_ev) m_ovf = 1;
      if (step_ev) m_step = 1;
      if (ovf_ev || step_ev) m_cnt = (m_cnt == SAT) ? SAT : m_cnt + 1;
   endtask

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".expected"}, int'(expected), m_expected());
      chk({tag, ".done"}, int'(done), int'(m_done));
      chk({tag, ".holding"}, int'(holding), int'(m_sync && m_last == MAXC));
      chk({tag, ".err_overflow"}, int'(err_overflow), int'(m_ovf));
      chk({tag, ".err_step"}, int'(err_step), int'(m_step));
      chk({tag, ".err_count"}, int'(err_count), m_cnt);
   endtask

   task automatic step(input string tag, input bit v, input int val, input bit clr);
      cnt_valid = v; cnt_in = val[CNT_W-1:0]; clear_err = clr;
      @(posedge clk);
      model_update(v, val, clr);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1; cnt_valid = 1'b0; clear_err = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all("reset");
      reset = 1'b0;
   endtask

   initial begin
      int seq_legal[6] = '{0, 1, 2, 3, 3, 3};
      int r, val;

      model_reset();
      do_reset();

      // legal run with hold at terminal value
      foreach (seq_legal[i]) step("legal", 1, seq_legal[i], 0);
      chk("legal.final_expected", int'(expected), 3);
      chk("legal.final_holding", int'(holding), 1);

      // overflow then resync
      do_reset();
      step("ovf", 1, 0, 0); step("ovf", 1, 1, 0); step("ovf", 1, 2, 0); step("ovf", 1, 4, 0);
      chk("ovf.err_count", int'(err_count), 1);
      chk("ovf.expected0", int'(expected), 0);
      step("ovf.resync", 1, 0, 0);
      chk("ovf.resync_expected", int'(expected), 1);

      // skip then overflow; both sticky flags set
      do_reset();
      step("skip", 1, 0, 0); step("skip", 1, 2, 0);
      step("skip.ovf", 1, 5, 0);
      chk("skip.both_flags", int'({err_overflow, err_step}), 3);
      chk("skip.err_count", int'(err_count), 2);

      // gaps and restart from terminal value
      do_reset();
      step("gap", 1, 0, 0);
      repeat (3) step("gap.idle", 0, 6, 0);
      step("gap", 1, 1, 0); step("gap", 1, 1, 0); step("gap", 1, 2, 0);
      step("gap.done", 1, 3, 0);
      chk("gap.done_pulse", int'(done), 1);
      step("gap.restart", 1, 0, 0);
      chk("gap.holding_drop", int'(holding), 0);
      step("gap", 1, 1, 0);
      chk("gap.final_expected", int'(expected), 2);

      // saturation and clear racing an event
      do_reset();
      repeat (260) step("sat", 1, 5, 0);
      chk("sat.err_count", int'(err_count), SAT);
      step("sat.clear_ovf", 1, 7, 1);
      chk("sat.clear_count", int'(err_count), 1);
      step("sat.clear_only", 0, 0, 1);

      // reset mid-sequence
      do_reset();
      step("midrst", 1, 0, 0); step("midrst", 1, 1, 0);
      do_reset();
      step("midrst.ign", 1, 2, 0);
      chk("midrst.expected0", int'(expected), 0);
      step("midrst.sync", 1, 0, 0);

      // randomized stream, mostly legal advances with occasional faults
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         if (m_sync && r < 6)
            val = (m_last == MAXC) ? ((r < 3) ? 0 : MAXC) : ((r < 5) ? m_last + 1 : m_last);
         else if (r < 7)
            val = 0;
         else
            val = int'($urandom_range(0, 7));
         step("rand", ($urandom_range(0, 4) != 0), val, ($urandom_range(0, 31) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
- Receive-side monitor for a bounded up-counter stream, meant to sit downstream of any producer that must count 0,1,2,…,MAX_COUNT and never go higher.
- Samples the count bus each valid cycle, tracks the expected next value, and flags overflow, skipped/backward steps, and premature restarts.
- Reports completion and a saturating error tally to the status/interrupt logic.

Parameters:
- CNT_W, 3, width of observed count bus
- MAX_COUNT, 3, terminal value; must be < 2**CNT_W
- ERRCNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- cnt_in  in  CNT_W  observed count value
- cnt_valid  in  1  cnt_in is meaningful this cycle
- clear_err  in  1  clears sticky flags and err_count
- expected  out  CNT_W  next value the checker expects
- done  out  1  1-cycle pulse when MAX_COUNT is first reached
- holding  out  1  level: in DONE state (counter parked at MAX_COUNT)
- err_overflow  out  1  sticky: cnt_in > MAX_COUNT observed
- err_step  out  1  sticky: illegal step (skip, backward, early restart)
- err_count  out  ERRCNT_W  saturating count of error events

Behaviour:
- Reset (sync, priority over everything): state=IDLE; expected=0; done=0; holding=0; err_overflow=0; err_step=0; err_count=0.
- All decisions are made only on cycles with cnt_valid=1. cnt_valid=0 leaves state, expected, and flags unchanged, and forces done=0.
- States:
  - IDLE: waits for cnt_in==0 -> TRACK, expected<=1. A nonzero in-range value stays in IDLE with no error (not yet synchronised).
  - TRACK: cnt_in==expected -> expected<=expected+1. If cnt_in==MAX_COUNT -> DONE, done=1 for one cycle, expected<=MAX_COUNT. cnt_in==expected-1 (repeat/hold) is legal: no change, no error. Any other in-range value -> err_step event, state<=IDLE, expected<=0.
  - DONE: holding=1. cnt_in==MAX_COUNT is legal. cnt_in==0 is a legal restart -> TRACK, expected<=1, holding drops next cycle. Any other in-range value -> err_step event -> IDLE.
- Overflow: in any state, cnt_in>MAX_COUNT -> err_overflow event, state<=IDLE, expected<=0. This takes precedence over the step check; only one event is counted per cycle.
- Error events:
  - Set the matching sticky flag the cycle after the offending sample.
  - err_count increments by 1 per event and saturates at 2**ERRCNT_W-1 (no wrap).
- clear_err: next cycle err_overflow=0, err_step=0, err_count=0. State and expected are unaffected.
- clear_err together with an error event in the same cycle: clear wins for the existing values, then the new event applies, so the result is flag=1 and err_count=1.
- done is registered with 1-cycle latency from the sample. expected, holding, and the flags are all registered outputs.
- Reset mid-sequence returns to IDLE immediately; the first sample after reset must be 0 to resynchronise.

Decomposition:
- Shared package count_chk_pkg:
  - state enum {IDLE, TRACK, DONE}
  - localparam defaults for CNT_W, MAX_COUNT
  - error-event encoding {EV_NONE, EV_OVF, EV_STEP}
- One sub-module: sat_counter (ERRCNT_W-wide, inc/clear inputs, saturating), instanced for err_count.
- The FSM and flag logic stay in the top module.

Test Plan:
- Legal run: reset, valid stream 0,1,2,3,3,3 -> done=1 exactly one cycle after the 3 sample, holding=1 afterwards, err_count=0, expected=3.
- Overflow: 0,1,2,4 -> err_overflow=1, err_step=0, err_count=1, state IDLE, expected=0; a following 0 resumes TRACK with expected=1.
- Skip: 0,2 -> err_step=1, err_count=1; then 5 -> err_overflow=1, err_count=2; both flags remain set.
- Gaps and restart: 0,(valid=0 x3),1,1,2,3,0,1 -> no errors, one done pulse, expected=2 at the end, holding deasserted after the 0.
- Saturation/clear: force 260 overflow events with ERRCNT_W=8 -> err_count=255; clear_err with a simultaneous overflow -> err_count=1, err_overflow=1.
- Reset mid-run: 0,1 then reset for 1 cycle, then 2 -> no error (IDLE ignores in-range nonzero), expected=0; then 0 -> TRACK.
